seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the eight-digit seven-segment display. It holds a double-buffered frame of eight 6-bit display codes. It walks a one-hot digit select across the eight digit slots and presents the code for the current digit. Its outputs `choose` and `display_data` drive the segment decoder directly: `choose` bits 7..4 select the left tube group, bits 3..0 the right group.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot; must be ≥2; frame period = 8*SCAN_DIV.
- `BLANK_CYCLES`, 1000: guard cycles at the start of each slot; used only with `SEG_SCAN_BLANK_EN`; must be < SCAN_DIV.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  write one code into the shadow buffer this cycle.
- `wr_addr`  in  3  shadow slot index; 0 is the rightmost digit (`choose` bit 0).
- `wr_data`  in  6  display code `dis0`..`dis23`; stored unchanged, not range-checked.
- `commit`  in  1  request a shadow-to-active copy at the next frame boundary.
- `digit_en`  in  8  per-digit enable mask; a 0 bit forces `choose`=0 during that slot.
- `busy`  out  1  commit pending.
- `commit_done`  out  1  one-cycle pulse after the copy.
- `choose`  out  8  one-hot digit select, registered.
- `display_data`  out  6  code for the selected digit, registered.

## Operation
- Divider `div` counts 0..SCAN_DIV-1 and wraps. On wrap, digit index `idx` advances 0→1→…→7→0.
- Frame boundary = the cycle with div==SCAN_DIV-1 and idx==7.
- Output register, every cycle: `choose` <= digit_en[idx] ? (1<<idx) : 0, and `display_data` <= active[idx]. `display_data` updates even when the digit is masked.
- Writes go to the shadow buffer only and never to the active buffer.
- `commit` sets `pending`. A commit while pending is already set has no further effect.
- On the boundary edge, if `pending` is set or `commit` is high that cycle: active <= shadow (all 8 entries), `pending` cleared, `commit_done` high for the next cycle.
- Write and copy in the same cycle: the copy takes the pre-write shadow value; the write lands in shadow only.
- `busy` = `pending`.
- Reset values: `choose`=8'h00, `display_data`=6'd0, `busy`=0, `commit_done`=0. Internal reset: div=0, idx=0, pending=0, both buffers all 6'd0.
- Reset mid-frame forces all of the above immediately (asynchronous). Scanning restarts at slot 0 on the first edge after release.

## Timing
- `choose` and `display_data` follow `idx` with one cycle of latency.
- Each slot lasts exactly SCAN_DIV cycles. `idx` becomes k at post-reset edge k*SCAN_DIV; `choose` shows bit k one edge later.
- First `choose`=8'h01 appears after the first edge following reset release.
- A `commit` request is serviced at the next frame boundary, after at most 8*SCAN_DIV cycles. Slot 0 of the new frame already shows the new data.
- `digit_en` is sampled every cycle and takes effect with one cycle of latency.

## Configuration
- Macro `SEG_SCAN_BLANK_EN` defined: `choose`=8'h00 while div < BLANK_CYCLES, i.e. a guard interval at the start of every slot that suppresses ghosting. `display_data` is unaffected.
- Macro undefined: no guard interval; `BLANK_CYCLES` is ignored.

## Structure
- Shared package `seg_pkg`:
  - `DIGITS`=8, `CODE_W`=6.
  - digit code constants `dis0`..`dis23`, identical to the existing constants header.
  - typedef `seg_code_t` (6-bit).
- Natural sub-module: `seg_scan_div`, the divider/index counter. It produces `idx`, `div`, and a `frame_end` strobe.

## Test plan
All scenarios use SCAN_DIV=4 and BLANK_CYCLES=1.
- Reset release, digit_en=8'hFF -> `choose`=01 after edge 1, 02 after edge 5, 80 after edge 29, 01 after edge 33; `display_data`=0 throughout.
- Write addr 3 data 5 with no commit -> `display_data` never 5. Then pulse `commit` -> `busy`=1 until the boundary; `commit_done` pulses once; `choose`=08 is paired with `display_data`=5 from the next frame on.
- digit_en=8'h0F -> `choose`=00 during slots 4..7; `display_data` still cycles through the active codes.
- On the boundary cycle, commit=1 together with a write of addr 0 data 9 (shadow[0] previously 2) -> active[0]=2. A second commit later yields 9.
- rst_n low during slot 5 with pending set -> `choose`=00, `display_data`=0, `busy`=0 immediately. After release, slot 0 shows code 0.
- With `SEG_SCAN_BLANK_EN` defined -> `choose`=00 for the first cycle of every slot, then one-hot for the remaining 3 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg : shared widths, code type and digit-code constants for the  |
// |           seven-segment scan controller.                             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int DIGITS = 8;
  localparam int CODE_W = 6;
  localparam int IDX_W  = 3;

  typedef logic [CODE_W-1:0] seg_code_t;
  typedef logic [IDX_W-1:0]  seg_idx_t;

  localparam seg_code_t dis0  = 6'd0;
  localparam seg_code_t dis1  = 6'd1;
  localparam seg_code_t dis2  = 6'd2;
  localparam seg_code_t dis3  = 6'd3;
  localparam seg_code_t dis4  = 6'd4;
  localparam seg_code_t dis5  = 6'd5;
  localparam seg_code_t dis6  = 6'd6;
  localparam seg_code_t dis7  = 6'd7;
  localparam seg_code_t dis8  = 6'd8;
  localparam seg_code_t dis9  = 6'd9;
  localparam seg_code_t dis10 = 6'd10;
  localparam seg_code_t dis11 = 6'd11;
  localparam seg_code_t dis12 = 6'd12;
  localparam seg_code_t dis13 = 6'd13;
  localparam seg_code_t dis14 = 6'd14;
  localparam seg_code_t dis15 = 6'd15;
  localparam seg_code_t dis16 = 6'd16;
  localparam seg_code_t dis17 = 6'd17;
  localparam seg_code_t dis18 = 6'd18;
  localparam seg_code_t dis19 = 6'd19;
  localparam seg_code_t dis20 = 6'd20;
  localparam seg_code_t dis21 = 6'd21;
  localparam seg_code_t dis22 = 6'd22;
  localparam seg_code_t dis23 = 6'd23;

  function automatic logic [DIGITS-1:0] digit_onehot(input seg_idx_t idx);
    digit_onehot      = '0;
    digit_onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_ctrl_if : frame-write, commit and display signals of the    |
// |                    scan controller.                                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic              wr_en;
  seg_idx_t          wr_addr;
  seg_code_t         wr_data;
  logic              commit;
  logic [DIGITS-1:0] digit_en;
  logic              busy;
  logic              commit_done;
  logic [DIGITS-1:0] choose;
  seg_code_t         display_data;

  modport master (
    output wr_en, wr_addr, wr_data, commit, digit_en,
    input  busy, commit_done, choose, display_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, digit_en,
    output busy, commit_done, choose, display_data
  );

endinterface
`default_nettype wire

// File: rtl/seg_scan_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_div : slot divider and digit index counter; flags the last  |
// |                cycle of every frame.                                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg_scan_div
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  output      seg_idx_t         idx,
  output      logic [DIV_W-1:0] div,
  output      logic             frame_end
);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam seg_idx_t         c_idx_last = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0] r_div;
  seg_idx_t         r_idx;
  logic             w_slot_end;

  assign w_slot_end = (r_div == c_div_last);

  // The index is exactly IDX_W bits wide, so 7 -> 0 wraps by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_div <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign idx       = r_idx;
  assign div       = r_div;
  assign frame_end = w_slot_end && (r_idx == c_idx_last);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_ctrl : double-buffered eight-digit scan controller.         |
// |                 Define SEG_SCAN_BLANK_EN for a per-slot guard blank. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  seg_idx_t          w_idx;
  logic [DIV_W-1:0]  w_div;
  logic              w_frame_end;
  logic              w_copy;
  logic              w_guard;
  logic [DIGITS-1:0] w_choose_next;

  seg_code_t         r_shadow [DIGITS];
  seg_code_t         r_active [DIGITS];
  logic              r_pending;
  logic              r_commit_done;
  logic [DIGITS-1:0] r_choose;
  seg_code_t         r_display_data;

  seg_scan_div #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (w_idx),
    .div       (w_div),
    .frame_end (w_frame_end)
  );

`ifdef SEG_SCAN_BLANK_EN
  localparam logic [DIV_W-1:0] c_blank = DIV_W'(BLANK_CYCLES);
  assign w_guard = (w_div < c_blank);
`else
  logic w_unused_div;
  assign w_unused_div = ^{w_div, BLANK_CYCLES[0]};
  assign w_guard      = 1'b0;
`endif

  // A commit arriving on the boundary cycle itself is honoured immediately.
  assign w_copy = w_frame_end && (r_pending || bus.commit);

  always_comb begin
    w_choose_next = '0;
    if (bus.digit_en[w_idx] && !w_guard) begin
      w_choose_next = digit_onehot(w_idx);
    end
  end

  // Non-blocking copy means a same-cycle write is not seen by the active frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '{default: '0};
      r_active <= '{default: '0};
    end else begin
      if (bus.wr_en) begin
        r_shadow[bus.wr_addr] <= bus.wr_data;
      end
      if (w_copy) begin
        r_active <= r_shadow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= 1'b0;
      r_commit_done  <= 1'b0;
      r_choose       <= '0;
      r_display_data <= '0;
    end else begin
      r_pending      <= w_copy ? 1'b0 : (r_pending || bus.commit);
      r_commit_done  <= w_copy;
      r_choose       <= w_choose_next;
      r_display_data <= r_active[w_idx];
    end
  end

  assign bus.busy         = r_pending;
  assign bus.commit_done  = r_commit_done;
  assign bus.choose       = r_choose;
  assign bus.display_data = r_display_data;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_ctrl : directed plus random stimulus against a frame-    |
// |                    level model derived from the elapsed cycle count. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * SD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: elapsed edges since reset release, both frames, pending flag.
  int        m_cnt;
  logic [5:0] m_shadow [8];
  logic [5:0] m_active [8];
  bit        m_pending;
  logic [7:0] e_choose;
  logic [5:0] e_disp;
  bit        e_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_pending = 0;
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 6'd0;
      m_active[i] = 6'd0;
    end
    e_choose = 8'h00;
    e_disp   = 6'd0;
    e_done   = 0;
  endtask

  // What the outputs should show after one more clock edge with the current inputs.
  task automatic model_edge();
    int slot;
    int phase;
    bit blank;
    bit boundary;
    bit copy;
    slot  = (m_cnt / SD) % 8;
    phase = m_cnt % SD;
    blank = 0;
`ifdef SEG_SCAN_BLANK_EN
    blank = (phase < BC);
`endif
    e_choose = (bus.digit_en[slot] && !blank) ? 8'(1 << slot) : 8'h00;
    e_disp   = m_active[slot];
    boundary = ((m_cnt % FRAME) == FRAME - 1);
    copy     = boundary && (m_pending || bus.commit);
    e_done   = copy;
    if (copy) m_active = m_shadow;
    if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
    m_pending = copy ? 1'b0 : (m_pending || bus.commit);
    m_cnt++;
  endtask

  task automatic check_all();
    chk("choose", 32'(bus.choose), 32'(e_choose));
    chk("display_data", 32'(bus.display_data), 32'(e_disp));
    chk("busy", 32'(bus.busy), 32'(m_pending));
    chk("commit_done", 32'(bus.commit_done), 32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
  endtask

  // Advance until the model count modulo FRAME reaches the target (at most one frame).
  task automatic run_to(input int target);
    for (int i = 0; i < FRAME && (m_cnt % FRAME) != target; i++) tick();
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.commit   = 1'b0;
    bus.digit_en = 8'hFF;
    model_reset();

    // Reset values.
    #12;
    chk("rst_choose", 32'(bus.choose), 32'h00);
    chk("rst_display", 32'(bus.display_data), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.commit_done), 32'h0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    run(FRAME + 2);

    // Shadow write without commit must not reach the display; then commit.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 6'd5;
    tick();
    idle();
    run(5);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    run(2 * FRAME);

    // Mask the left group for a frame.
    bus.digit_en = 8'h0F;
    run(FRAME);
    bus.digit_en = 8'hFF;

    // Same-cycle write and boundary copy.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 6'd2;
    tick();
    idle();
    run_to(FRAME - 1);
    bus.commit = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 6'd9;
    tick();
    idle();
    tick();
    chk("copy_pre_write", 32'(bus.display_data), 32'd2);
    run(3);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    run_to(0);
    tick();
    chk("second_commit", 32'(bus.display_data), 32'd9);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_addr  = 3'($urandom);
      bus.wr_data  = 6'($urandom);
      bus.commit   = ($urandom_range(0, 15) == 0);
      bus.digit_en = 8'($urandom);
      tick();
    end
    idle();
    bus.digit_en = 8'hFF;
    run(FRAME);

    // Reset in slot 5 with a commit pending.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 6'd17;
    tick();
    idle();
    run_to(2 * SD);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    run_to(5 * SD + 1);
    chk("busy_before_reset", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_choose", 32'(bus.choose), 32'h00);
    chk("mid_rst_display", 32'(bus.display_data), 32'h00);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(FRAME + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
